// File: rtl/b06_pkg.sv
`default_nettype none
// ============================================================================
// Package  : b06_pkg
// Brief    : Shared types and constants for the b06 EQL request source.
// Revision : 1.0
// ============================================================================
package b06_pkg;

    // Request FSM states; the encoding is fixed here so every user agrees.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int unsigned c_CNT_W = 4;
    localparam int unsigned c_TMO_W = 3;

    localparam logic c_CH_A = 1'b0;
    localparam logic c_CH_B = 1'b1;

endpackage : b06_pkg
`default_nettype wire

// File: rtl/b06_cont_timer.sv
`default_nettype none
// ============================================================================
// Module   : b06_cont_timer
// Brief    : Count timer with live terminal-count compare and CONT_EQL flag.
// Revision : 1.0
// ============================================================================
module b06_cont_timer
    import b06_pkg::*;
#(
    parameter int unsigned CNT_W = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_term_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cont_eql
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_cont_eql;
    logic             w_match;

    // Compared live: a lowered terminal value lets the counter run to wrap.
    assign w_match = (r_cnt == i_term_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_cont_eql <= 1'b0;
        end else if (!i_enable) begin
            r_cnt      <= '0;
            r_cont_eql <= 1'b0;
        end else if (w_match) begin
            r_cnt      <= '0;
            r_cont_eql <= 1'b1;
        end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_cont_eql <= 1'b0;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cont_eql = r_cont_eql;

endmodule : b06_cont_timer
`default_nettype wire

// File: rtl/b06_eql_source.sv
`default_nettype none
// ============================================================================
// Module   : b06_eql_source
// Brief    : Latches two request lines and presents one registered EQL to b06,
//            holding it until ACKOUT or an ack timeout; owns the count timer.
// Revision : 1.0
// ============================================================================
module b06_eql_source
    import b06_pkg::*;
#(
    parameter int unsigned CNT_W = c_CNT_W,
    parameter int unsigned TMO_W = c_TMO_W
) (
    input  logic             clock,
    input  logic             RESET_G,
    input  logic             REQ_A,
    input  logic             REQ_B,
    input  logic [CNT_W-1:0] TERM_VAL,
    input  logic             ENABLE_COUNT,
    input  logic             ACKOUT,
    output logic             EQL,
    output logic             CONT_EQL,
    output logic [1:0]       PEND,
    output logic             SERVED,
    output logic [CNT_W-1:0] CNT
);

    // Last pre-fire count: the counter fires as it would reach all-ones,
    // giving 2**TMO_W-1 cycles of EQL high before an unanswered release.
    localparam logic [TMO_W-1:0] c_TMO_FIRE = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_eql;
    logic             w_eql_nxt;
    logic [1:0]       r_pend;
    logic [1:0]       w_pend_nxt;
    logic [1:0]       w_pend_clr;
    logic             r_served;
    logic             w_served_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_nxt;

    always_ff @(posedge clock or posedge RESET_G) begin
        if (RESET_G) begin
            r_state  <= ST_IDLE;
            r_eql    <= 1'b0;
            r_pend   <= 2'b00;
            r_served <= c_CH_A;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_eql    <= w_eql_nxt;
            r_pend   <= w_pend_nxt;
            r_served <= w_served_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_eql_nxt    = r_eql;
        w_served_nxt = r_served;
        w_tmo_nxt    = r_tmo;
        w_pend_clr   = 2'b00;

        case (r_state)
            ST_IDLE: begin
                w_eql_nxt = 1'b0;
                if (r_pend != 2'b00) begin
                    w_state_nxt  = ST_ASSERT;
                    w_eql_nxt    = 1'b1;
                    w_served_nxt = r_pend[c_CH_A] ? c_CH_A : c_CH_B;
                    w_tmo_nxt    = '0;
                end
            end
            ST_ASSERT: begin
                if (ACKOUT) begin
                    w_pend_clr[r_served] = 1'b1;
                    w_state_nxt          = ST_RELEASE;
                    w_eql_nxt            = 1'b0;
                    w_tmo_nxt            = '0;
                end else if (r_tmo == c_TMO_FIRE) begin
                    // Unanswered: drop EQL but keep the request pending.
                    w_state_nxt = ST_RELEASE;
                    w_eql_nxt   = 1'b0;
                    w_tmo_nxt   = '0;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
                w_eql_nxt   = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_eql_nxt   = 1'b0;
                w_tmo_nxt   = '0;
            end
        endcase
    end

    // Set dominates clear so a request arriving with its own ack survives.
    assign w_pend_nxt = (r_pend & ~w_pend_clr) | {REQ_B, REQ_A};

    b06_cont_timer #(
        .CNT_W (CNT_W)
    ) u_cont_timer (
        .clk        (clock),
        .rst        (RESET_G),
        .i_enable   (ENABLE_COUNT),
        .i_term_val (TERM_VAL),
        .o_cnt      (CNT),
        .o_cont_eql (CONT_EQL)
    );

    assign EQL    = r_eql;
    assign PEND   = r_pend;
    assign SERVED = r_served;

endmodule : b06_eql_source
`default_nettype wire
